// File: rtl/data_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Holds FSM states, store-size encodings and the store byte-lane helpers.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int BLOCK_W     = 128;
  localparam int OFFSET_W    = 4;
  localparam int BLOCK_BYTES = BLOCK_W / 8;

  // Byte enables inside the block; half ignores offset[0], word ignores offset[1:0].
  function automatic logic [BLOCK_BYTES-1:0] store_mask(input logic [1:0] size,
                                                        input logic [OFFSET_W-1:0] offset);
    logic [BLOCK_BYTES-1:0] m;
    m = '0;
    case (size)
      SZ_BYTE: m = 16'h0001 << offset;
      SZ_HALF: m = 16'h0003 << {offset[3:1], 1'b0};
      SZ_WORD: m = 16'h000F << {offset[3:2], 2'b00};
      default: m = '0;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data across the block so the mask picks the lane.
  function automatic logic [BLOCK_W-1:0] store_lanes(input logic [1:0] size,
                                                     input logic [31:0] wdata);
    logic [BLOCK_W-1:0] d;
    case (size)
      SZ_BYTE: d = {16{wdata[7:0]}};
      SZ_HALF: d = {8{wdata[15:0]}};
      default: d = {4{wdata}};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Per-line valid/dirty/tag/data storage with one combinational read port and
// one write port that either merges bytes (sets dirty) or installs a full block.
module dcache_line_store
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [BLOCK_W-1:0]     rd_data,
  input  logic                   wr_en,
  input  logic                   wr_install,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [BLOCK_BYTES-1:0] wr_be,
  input  logic [BLOCK_W-1:0]     wr_data,
  input  logic [TAG_W-1:0]       wr_tag
);

  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_mem [NUM_LINES];
  logic [BLOCK_W-1:0]   merged_block;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_merge
      assign merged_block[gi*8 +: 8] = wr_be[gi] ? wr_data[gi*8 +: 8]
                                                 : data_mem[wr_idx][gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      if (wr_install) begin
        valid_reg[wr_idx] <= 1'b1;
        dirty_reg[wr_idx] <= 1'b0;
      end else begin
        dirty_reg[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= merged_block;
      if (wr_install) tag_mem[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_dirty = dirty_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: hit logic,
// store merge and the IDLE/WRITEBACK/FETCH/UPDATE miss FSM with registered memory requests.
module data_cache_ctrl
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES   = 8,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [1:0]   READ,
  input  logic [1:0]   WRITE,
  input  logic [31:0]  ADDR,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         ERR,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFFSET_W - IDX_W;
  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   miss_idx_reg, miss_idx_next;
  logic [TAG_W-1:0]   miss_tag_reg, miss_tag_next;
  logic               mem_read_reg, mem_read_next;
  logic               mem_write_reg, mem_write_next;
  logic [27:0]        mem_addr_reg, mem_addr_next;
  logic [BLOCK_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [BLOCK_W-1:0] fill_reg, fill_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;
  logic               err_reg, err_next;

  logic [IDX_W-1:0]       addr_idx;
  logic [TAG_W-1:0]       addr_tag;
  logic                   acc, hit, tmo_expired, is_update;
  logic                   line_valid, line_dirty;
  logic [TAG_W-1:0]       line_tag;
  logic [BLOCK_W-1:0]     line_data;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;
  logic [BLOCK_BYTES-1:0] wr_be;
  logic [BLOCK_W-1:0]     wr_data;

  assign addr_idx = ADDR[OFFSET_W +: IDX_W];
  assign addr_tag = ADDR[31 -: TAG_W];
  assign acc      = (READ != 2'b00) || (WRITE != SZ_NONE);
  assign hit      = line_valid && (line_tag == addr_tag);
  assign BUSYWAIT = acc && ((state_reg != IDLE) || !hit);
  assign READDATA = hit ? line_data[{ADDR[3:2], 5'b00000} +: 32] : 32'h0;

  assign tmo_expired = (MEM_TIMEOUT > 0) && (tmo_reg == TMO_LAST);

  // Install wins in UPDATE; otherwise a store merges only on an IDLE hit.
  assign is_update = (state_reg == UPDATE);
  assign wr_en     = is_update || ((state_reg == IDLE) && acc && hit && (WRITE != SZ_NONE));
  assign wr_idx    = is_update ? miss_idx_reg : addr_idx;
  assign wr_be     = is_update ? '1 : store_mask(WRITE, ADDR[3:0]);
  assign wr_data   = is_update ? fill_reg : store_lanes(WRITE, WRITEDATA);

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk        (CLK),
    .rst_n      (RESET),
    .rd_idx     (addr_idx),
    .rd_valid   (line_valid),
    .rd_dirty   (line_dirty),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .wr_en      (wr_en),
    .wr_install (is_update),
    .wr_idx     (wr_idx),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .wr_tag     (miss_tag_reg)
  );

  always_comb begin
    state_next     = state_reg;
    miss_idx_next  = miss_idx_reg;
    miss_tag_next  = miss_tag_reg;
    mem_read_next  = mem_read_reg;
    mem_write_next = mem_write_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    fill_next      = fill_reg;
    tmo_next       = '0;
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (acc && !hit) begin
          miss_idx_next = addr_idx;
          miss_tag_next = addr_tag;
          if (line_valid && line_dirty) begin
            state_next     = WRITEBACK;
            mem_write_next = 1'b1;
            mem_addr_next  = {line_tag, addr_idx};
            mem_wdata_next = line_data;
          end else begin
            state_next    = FETCH;
            mem_read_next = 1'b1;
            mem_addr_next = ADDR[31:4];
          end
        end
      end
      WRITEBACK: begin
        if (!MEM_BUSYWAIT) begin
          state_next     = FETCH;
          mem_write_next = 1'b0;
          mem_read_next  = 1'b1;
          mem_addr_next  = {miss_tag_reg, miss_idx_reg};
        end else if (tmo_expired) begin
          state_next     = IDLE;
          mem_write_next = 1'b0;
          err_next       = 1'b1;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      FETCH: begin
        if (!MEM_BUSYWAIT) begin
          state_next    = UPDATE;
          mem_read_next = 1'b0;
          fill_next     = MEM_READDATA;
        end else if (tmo_expired) begin
          state_next    = IDLE;
          mem_read_next = 1'b0;
          err_next      = 1'b1;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      miss_idx_reg  <= '0;
      miss_tag_reg  <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      fill_reg      <= '0;
      tmo_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      miss_idx_reg  <= miss_idx_next;
      miss_tag_reg  <= miss_tag_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      fill_reg      <= fill_next;
      tmo_reg       <= tmo_next;
      err_reg       <= err_next;
    end
  end

  assign MEM_READ      = mem_read_reg;
  assign MEM_WRITE     = mem_write_reg;
  assign MEM_ADDRESS   = mem_addr_reg;
  assign MEM_WRITEDATA = mem_wdata_reg;
  assign ERR           = err_reg;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: block memory model with a fixed
// 5-cycle response plus one recovery cycle after each completion, and a READDATA scoreboard.
module tb_data_cache_ctrl;

  logic         CLK;
  logic         RESET;
  logic [1:0]   READ;
  logic [1:0]   WRITE;
  logic [31:0]  ADDR;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         ERR;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  data_cache_ctrl #(.NUM_LINES(8), .MEM_TIMEOUT(8)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDR(ADDR),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .ERR(ERR),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: busy while a request is held until its 5th cycle; the cycle
  // after a completion is a recovery cycle (busy) if a new request follows at once.
  logic [127:0] mem_blk [16];
  logic [15:0]  mem_wr_valid = '0;
  logic [2:0]   mem_cnt = '0;
  logic         mem_stuck = 1'b0;
  logic         mem_req;

  function automatic logic [127:0] pattern(input logic [27:0] ba);
    logic [127:0] p;
    for (int w = 0; w < 4; w++) p[w*32 +: 32] = {ba[23:0], 8'h10 + 8'(w)};
    return p;
  endfunction

  always_comb begin
    mem_req      = MEM_READ | MEM_WRITE;
    MEM_BUSYWAIT = mem_stuck | (mem_req && (mem_cnt != 3'd4));
    MEM_READDATA = mem_wr_valid[MEM_ADDRESS[3:0]] ? mem_blk[MEM_ADDRESS[3:0]] : pattern(MEM_ADDRESS);
  end

  always @(posedge CLK) begin
    if (!mem_req)               mem_cnt <= 3'd0;
    else if (mem_cnt == 3'd4)   mem_cnt <= 3'd5;
    else if (mem_cnt == 3'd5)   mem_cnt <= 3'd0;
    else                        mem_cnt <= mem_cnt + 3'd1;
    if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem_blk[MEM_ADDRESS[3:0]]      <= MEM_WRITEDATA;
      mem_wr_valid[MEM_ADDRESS[3:0]] <= 1'b1;
    end
  end

  int           rd_seen = 0;
  int           wr_seen = 0;
  int           both_seen = 0;
  logic [27:0]  last_rd_addr = '0;
  logic [27:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  always @(negedge CLK) begin
    if (MEM_READ) begin
      rd_seen      <= rd_seen + 1;
      last_rd_addr <= MEM_ADDRESS;
    end
    if (MEM_WRITE) begin
      wr_seen      <= wr_seen + 1;
      last_wr_addr <= MEM_ADDRESS;
      last_wr_data <= MEM_WRITEDATA;
    end
    if (MEM_READ && MEM_WRITE) both_seen <= both_seen + 1;
  end

  // Drives one access, counts stalled cycles, returns READDATA from the first non-stalled cycle.
  task automatic access(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                        input logic [31:0] d, output int stall, output logic [31:0] rdata);
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDR = a; WRITEDATA = d;
    stall = 0;
    rdata = 32'h0;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        rdata = READDATA;
        break;
      end
      stall++;
      if (stall > 200) begin
        checks++;
        $display("FAIL access_timeout addr=%h stall=%0d required BUSYWAIT to drop", a, stall);
        break;
      end
    end
    @(posedge CLK); #1;
    READ = 2'b00; WRITE = 2'b00;
  endtask

  task automatic test_reset();
    RESET = 1'b0; READ = 2'b00; WRITE = 2'b00; ADDR = '0; WRITEDATA = '0;
    repeat (2) @(negedge CLK);
    checks++; if (MEM_READ !== 1'b0) $display("FAIL reset_mem_read got=%b want=0", MEM_READ); else passed++;
    checks++; if (MEM_WRITE !== 1'b0) $display("FAIL reset_mem_write got=%b want=0", MEM_WRITE); else passed++;
    checks++; if (MEM_ADDRESS !== 28'h0) $display("FAIL reset_mem_addr got=%h want=0", MEM_ADDRESS); else passed++;
    checks++; if (MEM_WRITEDATA !== 128'h0) $display("FAIL reset_mem_wdata got=%h want=0", MEM_WRITEDATA); else passed++;
    checks++; if (ERR !== 1'b0) $display("FAIL reset_err got=%b want=0", ERR); else passed++;
    checks++; if (BUSYWAIT !== 1'b0) $display("FAIL reset_busywait got=%b want=0", BUSYWAIT); else passed++;
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_clean_miss();
    int stall, rd0, wr0;
    logic [31:0] got, want;
    rd0 = rd_seen; wr0 = wr_seen;
    exp_q.push_back(32'h0000_0410);
    access(2'b11, 2'b00, 32'h40, 32'h0, stall, got);
    want = exp_q.pop_front();
    $display("clean_miss load 0x40 stall=%0d rdata=%h", stall, got);
    checks++; if (stall !== 7) $display("FAIL clean_miss_stall got=%0d want=7", stall); else passed++;
    checks++; if (got !== want) $display("FAIL clean_miss_data got=%h want=%h", got, want); else passed++;
    checks++; if (rd_seen - rd0 !== 5) $display("FAIL clean_miss_fetch_cycles got=%0d want=5", rd_seen - rd0); else passed++;
    checks++; if (last_rd_addr !== 28'h4) $display("FAIL clean_miss_mem_addr got=%h want=4", last_rd_addr); else passed++;
    checks++; if (wr_seen !== wr0) $display("FAIL clean_miss_no_write got=%0d want=%0d", wr_seen, wr0); else passed++;
  endtask

  task automatic test_read_hit();
    int stall;
    logic [31:0] got, want;
    exp_q.push_back(32'h0000_0411);
    access(2'b01, 2'b00, 32'h44, 32'h0, stall, got);
    want = exp_q.pop_front();
    $display("read_hit load 0x44 stall=%0d rdata=%h", stall, got);
    checks++; if (stall !== 0) $display("FAIL read_hit_stall got=%0d want=0", stall); else passed++;
    checks++; if (got !== want) $display("FAIL read_hit_data got=%h want=%h", got, want); else passed++;
  endtask

  task automatic test_store_merge();
    logic [1:0]  rd_t [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01};
    logic [1:0]  wr_t [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
    logic [31:0] ad_t [8] = '{32'h45, 32'h44, 32'h4B, 32'h48, 32'h4F, 32'h4C, 32'h40, 32'h40};
    logic [31:0] wd_t [8] = '{32'hAB, 32'h0, 32'h1234_CDEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h55, 32'h0};
    logic [31:0] ex_t [8] = '{32'h0, 32'h0000_AB11, 32'h0, 32'hCDEF_0412, 32'h0, 32'hDEAD_BEEF,
                              32'h0000_0410, 32'h0000_0055};
    int stall;
    logic [31:0] got, want;
    for (int i = 0; i < 8; i++) begin
      if (rd_t[i] != 2'b00) exp_q.push_back(ex_t[i]);
      access(rd_t[i], wr_t[i], ad_t[i], wd_t[i], stall, got);
      $display("store_merge[%0d] rd=%b wr=%b addr=%h wdata=%h stall=%0d rdata=%h",
               i, rd_t[i], wr_t[i], ad_t[i], wd_t[i], stall, got);
      checks++; if (stall !== 0) $display("FAIL store_merge_stall[%0d] got=%0d want=0", i, stall); else passed++;
      if (rd_t[i] != 2'b00) begin
        want = exp_q.pop_front();
        checks++; if (got !== want) $display("FAIL store_merge_data[%0d] got=%h want=%h", i, got, want); else passed++;
      end
    end
  endtask

  task automatic test_dirty_evict();
    int stall, wr0, rd0, both0;
    logic [31:0]  got, want;
    logic [127:0] blk;
    blk = {32'hDEAD_BEEF, 32'hCDEF_0412, 32'h0000_AB11, 32'h0000_0055};
    wr0 = wr_seen; rd0 = rd_seen; both0 = both_seen;
    exp_q.push_back(32'h0000_0C11);
    access(2'b01, 2'b00, 32'hC4, 32'h0, stall, got);
    want = exp_q.pop_front();
    $display("dirty_evict load 0xC4 stall=%0d rdata=%h wb_addr=%h", stall, got, last_wr_addr);
    checks++; if (stall !== 13) $display("FAIL evict_stall got=%0d want=13", stall); else passed++;
    checks++; if (got !== want) $display("FAIL evict_data got=%h want=%h", got, want); else passed++;
    checks++; if (wr_seen - wr0 !== 5) $display("FAIL evict_wb_cycles got=%0d want=5", wr_seen - wr0); else passed++;
    checks++; if (last_wr_addr !== 28'h4) $display("FAIL evict_wb_addr got=%h want=4", last_wr_addr); else passed++;
    checks++; if (last_wr_data[47:40] !== 8'hAB) $display("FAIL evict_wb_byte5 got=%h want=ab", last_wr_data[47:40]); else passed++;
    checks++; if (last_wr_data !== blk) $display("FAIL evict_wb_block got=%h want=%h", last_wr_data, blk); else passed++;
    checks++; if (last_rd_addr !== 28'hC) $display("FAIL evict_fetch_addr got=%h want=c", last_rd_addr); else passed++;
    checks++; if (rd_seen - rd0 !== 6) $display("FAIL evict_fetch_cycles got=%0d want=6", rd_seen - rd0); else passed++;
    checks++; if (both_seen !== both0) $display("FAIL evict_rd_wr_overlap got=%0d want=%0d", both_seen, both0); else passed++;
    // The installed 0xC4 line is clean, so bringing 0x44 back must not write back.
    wr0 = wr_seen;
    exp_q.push_back(32'h0000_AB11);
    access(2'b01, 2'b00, 32'h44, 32'h0, stall, got);
    want = exp_q.pop_front();
    $display("dirty_evict reload 0x44 stall=%0d rdata=%h", stall, got);
    checks++; if (stall !== 7) $display("FAIL reload_stall got=%0d want=7", stall); else passed++;
    checks++; if (got !== want) $display("FAIL reload_data got=%h want=%h", got, want); else passed++;
    checks++; if (wr_seen !== wr0) $display("FAIL reload_no_wb got=%0d want=%0d", wr_seen, wr0); else passed++;
  endtask

  task automatic test_reset_mid_miss();
    int stall;
    logic [31:0] got, want;
    @(posedge CLK); #1;
    READ = 2'b11; ADDR = 32'h24;
    repeat (3) @(negedge CLK);
    checks++; if (MEM_READ !== 1'b1) $display("FAIL midreset_fetching got=%b want=1", MEM_READ); else passed++;
    #2; RESET = 1'b0; #1;
    $display("reset_mid_miss RESET low: MEM_READ=%b MEM_ADDRESS=%h", MEM_READ, MEM_ADDRESS);
    checks++; if (MEM_READ !== 1'b0) $display("FAIL midreset_mem_read got=%b want=0", MEM_READ); else passed++;
    checks++; if (MEM_ADDRESS !== 28'h0) $display("FAIL midreset_mem_addr got=%h want=0", MEM_ADDRESS); else passed++;
    READ = 2'b00;
    @(negedge CLK); RESET = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      checks++; if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0)
        $display("FAIL midreset_idle got busy=%b mem_read=%b want 0/0", BUSYWAIT, MEM_READ); else passed++;
    end
    exp_q.push_back(32'h0000_AB11);
    access(2'b01, 2'b00, 32'h44, 32'h0, stall, got);
    want = exp_q.pop_front();
    $display("reset_mid_miss load 0x44 stall=%0d rdata=%h", stall, got);
    checks++; if (stall !== 7) $display("FAIL midreset_miss_stall got=%0d want=7", stall); else passed++;
    checks++; if (got !== want) $display("FAIL midreset_miss_data got=%h want=%h", got, want); else passed++;
  endtask

  task automatic test_timeout();
    int stall, rd0;
    logic [31:0] got, want;
    mem_stuck = 1'b1;
    rd0 = rd_seen;
    @(posedge CLK); #1;
    READ = 2'b01; ADDR = 32'h80;
    repeat (9) @(negedge CLK);
    checks++; if (ERR !== 1'b0 || MEM_READ !== 1'b1)
      $display("FAIL timeout_early got err=%b mem_read=%b want 0/1", ERR, MEM_READ); else passed++;
    READ = 2'b00;
    @(negedge CLK);
    $display("timeout after 8 fetch cycles: ERR=%b MEM_READ=%b BUSYWAIT=%b", ERR, MEM_READ, BUSYWAIT);
    checks++; if (ERR !== 1'b1) $display("FAIL timeout_err got=%b want=1", ERR); else passed++;
    checks++; if (MEM_READ !== 1'b0) $display("FAIL timeout_mem_read got=%b want=0", MEM_READ); else passed++;
    checks++; if (BUSYWAIT !== 1'b0) $display("FAIL timeout_busywait got=%b want=0", BUSYWAIT); else passed++;
    checks++; if (rd_seen - rd0 !== 8) $display("FAIL timeout_fetch_cycles got=%0d want=8", rd_seen - rd0); else passed++;
    mem_stuck = 1'b0;
    @(negedge CLK);
    checks++; if (MEM_READ !== 1'b0) $display("FAIL timeout_stays_idle got=%b want=0", MEM_READ); else passed++;
    exp_q.push_back(32'h0000_0810);
    access(2'b01, 2'b00, 32'h80, 32'h0, stall, got);
    want = exp_q.pop_front();
    $display("timeout retry load 0x80 stall=%0d rdata=%h ERR=%b", stall, got, ERR);
    checks++; if (stall !== 7) $display("FAIL timeout_line_invalid got=%0d want=7", stall); else passed++;
    checks++; if (got !== want) $display("FAIL timeout_retry_data got=%h want=%h", got, want); else passed++;
    checks++; if (ERR !== 1'b1) $display("FAIL timeout_err_sticky got=%b want=1", ERR); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_store_merge();
    test_dirty_evict();
    test_reset_mid_miss();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache between the CPU memory-access stage and the block-wide main data memory. It takes the MA-stage read/write request and returns the load word, or raises BUSYWAIT so the pipeline stalls through a miss. Misses are serviced through a 4-state FSM that writes back a dirty victim, then fetches the new 128-bit block.

Parameters:
NUM_LINES, 8, number of cache lines; power of two, at least 2; IDX_W = log2(NUM_LINES).
MEM_TIMEOUT, 0, 0 = no timeout; otherwise the maximum cycles to wait on MEM_BUSYWAIT before the FSM returns to IDLE and flags ERR.

Ports:
CLK  in  1  single clock; all state updates on the rising edge.
RESET  in  1  active-low asynchronous reset.
READ  in  2  load request; 2'b00 = none, any nonzero value = load.
WRITE  in  2  store size; 2'b00 = none, 01 = byte, 10 = half, 11 = word.
ADDR  in  32  byte address from the MA-stage ALU result.
WRITEDATA  in  32  store data, right-aligned.
READDATA  out  32  aligned word selected by ADDR[3:2].
BUSYWAIT  out  1  stall request to the pipeline.
ERR  out  1  sticky; set on a memory timeout, cleared only by reset.
MEM_READ  out  1  block fetch request.
MEM_WRITE  out  1  block writeback request.
MEM_ADDRESS  out  28  block address (byte address bits [31:4]).
MEM_WRITEDATA  out  128  victim block.
MEM_READDATA  in  128  fetched block.
MEM_BUSYWAIT  in  1  memory is busy; the transfer completes on the first cycle this is low while a request is held.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Address split: offset = ADDR[3:0], index = ADDR[4+IDX_W-1:4], tag = ADDR[31:4+IDX_W].
- Per line: valid, dirty, tag, 128-bit data.
- Reset:
  - all valid and dirty bits clear; state = IDLE; ERR = 0; timeout counter = 0.
  - MEM_READ, MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA = 0.
  - reset asserted mid-miss aborts the transfer immediately; memory requests drop asynchronously.
- Access request: acc = (READ != 0) or (WRITE != 0). If both are nonzero, the write is performed and the returned word is the pre-write value.
- hit = valid and tag match at the index (combinational).
- BUSYWAIT = acc and (state != IDLE or not hit). It is low whenever acc = 0.
- READDATA:
  - the selected word when hit, otherwise 32'h0. It is never sign-extended; byte/half extraction is done downstream.
- Read hit: zero wait; READDATA is valid in the same cycle.
- Write hit:
  - BUSYWAIT stays low; the merge commits on the next CLK edge and sets dirty.
  - byte stores to lane ADDR[1:0]; half stores to lane ADDR[1] (ADDR[0] ignored); word uses ADDR[3:2] (ADDR[1:0] ignored).
- FSM states IDLE, WRITEBACK, FETCH, UPDATE:
  - IDLE, miss with victim valid and dirty -> WRITEBACK; miss otherwise -> FETCH; hit or no access -> IDLE.
  - WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {victim tag, index}, MEM_WRITEDATA = victim data. Go to FETCH on the first cycle MEM_BUSYWAIT = 0.
  - FETCH: MEM_READ = 1, MEM_ADDRESS = ADDR[31:4]. Go to UPDATE on the first cycle MEM_BUSYWAIT = 0, capturing MEM_READDATA.
  - UPDATE (one cycle): install the block, valid = 1, dirty = 0, tag written. Go to IDLE. The pending access then hits in IDLE; a write merges on the following edge and sets dirty.
- Memory outputs are registered: MEM_READ and MEM_WRITE are never high together and drop in the cycle after completion.
- Timeout: if MEM_TIMEOUT > 0 and a request is held MEM_TIMEOUT cycles, go to IDLE with ERR = 1 and the line unchanged.
- Miss latency: clean = 1 + fetch time + 1 cycles; dirty adds the writeback time.
- ADDR, READ and WRITE must be held stable by the pipeline while BUSYWAIT = 1. Changing them mid-miss is undefined apart from the index and tag already latched.

Decomposition:
- Shared package data_cache_pkg:
  - state enum (IDLE, WRITEBACK, FETCH, UPDATE).
  - size encodings SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD.
  - BLOCK_W = 128, OFFSET_W = 4.
- One sub-module, dcache_line_store: the valid/dirty/tag/data arrays with async-low clear, one combinational read port, and a write port taking a byte-enable merge or a full-block install.
- The FSM, hit logic and store merge live in data_cache_ctrl.

Test Plan:
Bench memory model with fixed 5-cycle MEM_BUSYWAIT.
- Reset, then READ=2'b11, ADDR=32'h40 -> BUSYWAIT high 7 cycles (IDLE, FETCH x5, UPDATE), MEM_READ with MEM_ADDRESS=28'h4; then READDATA equals model word 0; MEM_WRITE never asserted.
- Load ADDR 32'h44 immediately after -> BUSYWAIT=0, READDATA=model word 1 in the same cycle.
- WRITE=2'b01, ADDR=32'h45, WRITEDATA=32'hAB on the cached line -> no stall; then load 32'h44 -> byte lane 1 = 8'hAB, other lanes unchanged, dirty set.
- Load 32'hC4 (same index 4, different tag) -> WRITEBACK with MEM_ADDRESS=28'h4 and MEM_WRITEDATA holding 8'hAB at byte 5, then FETCH 28'hC; total stall 13 cycles.
- Drop RESET low during FETCH -> MEM_READ falls within the reset assertion, BUSYWAIT stays low after release with no access, and the previously cached 32'h44 misses.
- MEM_TIMEOUT=8 with MEM_BUSYWAIT tied high -> ERR=1 after 8 FETCH cycles, state IDLE, line not valid.
